// File: rtl/fifo_memory.sv
// Synchronous FIFO on a register-array memory with occupancy count, status flags and error pulses.
// Latency: one clock from an accepted pop to data_out; flags follow count with no extra delay.
// Backpressure: a push while full is rejected (overflow pulse) unless a pop frees a slot on the
//   same edge; a pop while empty is rejected (underflow pulse) and data_out holds.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high; wins over we/re
//   we, data_in  push request and write word
//   re           pop request
//   data_out     registered read word, updated only on an accepted pop
//   count        stored words, 0..DEPTH
//   empty/full/almost_full  combinational decodes of count
//   overflow/underflow      one-cycle pulses for rejected push/pop
module fifo_memory #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 2,
  parameter int AF_LEVEL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LEVEL);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign almost_full = (count >= AF_CNT);

  // A pop on the same edge frees the head slot, so a full FIFO can still take a push.
  // When empty, the pop is rejected even if a push lands on the same edge (no fall-through).
  assign push_ok = we & (~full | re);
  assign pop_ok  = re & ~empty;

  // Storage is deliberately not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= we & full & ~re;
      underflow <= re & empty;

      // Pointers wrap naturally at DEPTH since they are exactly ADDR_W bits wide.
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end

      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_memory.sv
// Self-checking bench for fifo_memory: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_fifo_memory;

  localparam int WIDTH    = 8;
  localparam int ADDR_W   = 2;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              we = 1'b0;
  logic              re = 1'b0;
  logic [WIDTH-1:0]  data_in = '0;
  logic [WIDTH-1:0]  data_out;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  fifo_memory #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .AF_LEVEL(AF_LEVEL)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .data_in(data_in),
    .data_out(data_out), .count(count), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: contents as a plain queue, plus last read word and error pulses.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  bit               m_ov = 1'b0;
  bit               m_un = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count",       32'(count),       32'(q.size()));
    chk("empty",       32'(empty),       32'(q.size() == 0));
    chk("full",        32'(full),        32'(q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF_LEVEL));
    chk("data_out",    32'(data_out),    32'(m_dout));
    chk("overflow",    32'(overflow),    32'(m_ov));
    chk("underflow",   32'(underflow),   32'(m_un));
  endtask

  // One clock: drive on the falling edge, advance the model at the rising edge, check 1ns later.
  task automatic step(input bit r, input bit w, input bit rd, input logic [WIDTH-1:0] din);
    bit was_full, was_empty;
    @(negedge clk);
    rst = r; we = w; re = rd; data_in = din;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_dout = '0;
      m_ov   = 1'b0;
      m_un   = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ov = w && was_full && !rd;
      m_un = rd && was_empty;
      if (rd && !was_empty) m_dout = q.pop_front();
      if (w && (!was_full || rd)) q.push_back(din);
    end
    #1;
    check_all();
  endtask

  initial begin : main
    logic [WIDTH-1:0] seq [4];
    seq[0] = 8'd3; seq[1] = 8'd6; seq[2] = 8'd9; seq[3] = 8'd12;

    // Reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_empty", 32'(empty), 32'd1);

    // Fill to full
    for (int i = 0; i < 4; i++) step(0, 1, 0, seq[i]);
    chk("t1_full", 32'(full), 32'd1);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      chk("t2_order", 32'(data_out), 32'(seq[i]));
    end
    chk("t2_empty", 32'(empty), 32'd1);

    // Overflow: rejected push must not disturb contents
    for (int i = 0; i < 4; i++) step(0, 1, 0, seq[i]);
    step(0, 1, 0, 8'd15);
    chk("t3_overflow", 32'(overflow), 32'd1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      chk("t3_drain", 32'(data_out), 32'(seq[i]));
    end

    // Underflow on empty: data_out holds
    step(0, 0, 1, 0);
    chk("t4_underflow", 32'(underflow), 32'd1);
    chk("t4_hold", 32'(data_out), 32'd12);

    // Simultaneous push/pop: mid-level, full, empty
    step(0, 1, 0, 8'd1);
    step(0, 1, 0, 8'd2);
    step(0, 1, 1, 8'd20);
    chk("t5_mid_count", 32'(count), 32'd2);
    step(0, 1, 0, 8'd30);
    step(0, 1, 0, 8'd31);
    step(0, 1, 1, 8'd21);
    chk("t5_full_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("t5_last", 32'(data_out), 32'd21);
    step(0, 1, 1, 8'd22);
    chk("t5_empty_un", 32'(underflow), 32'd1);
    chk("t5_empty_cnt", 32'(count), 32'd1);
    step(0, 0, 1, 0);

    // Interleaved traffic across pointer wrap, then reset mid-operation
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 8'(i));
    for (int i = 4; i <= 10; i++) begin
      step(0, 1, 1, 8'(i));
      chk("t6_order", 32'(data_out), 32'(i - 3));
    end
    chk("t6_count", 32'(count), 32'd3);
    step(1, 0, 0, 0);
    chk("t6_rst_dout", 32'(data_out), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
